conv_3d: RTL and testbench
==========================

# conv_3d

Streaming 3-D convolution engine for volumetric data: accepts one unsigned voxel per cycle in raster order (w fastest, then h, then d), holds a sliding K1×K2×K3 window in an internal delay buffer, and emits one fixed-point result per fully populated window.
It sits between a volume source (DMA or sensor stream) and a downstream result sink, processing one volume per `last_in` framing.

## Interface
- `K1`, 3: kernel depth (d axis)
- `K2`, 3: kernel height (h axis)
- `K3`, 3: kernel width (w axis)
- `D`, 8: volume depth
- `H`, 64: volume height
- `W`, 64: volume width
- `DATA_W`, 8: voxel and weight width, unsigned
- Derived: `OUT_W` = DATA_W+4; `ACC_W` = 2·DATA_W + ceil(log2(K1·K2·K3))

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `voxel_in` in DATA_W: input voxel
- `valid_in` in 1: voxel_in is valid this cycle
- `kernel` in K1·K2·K3·DATA_W: flattened weights; weight (kd,kh,kw) at bits [((kd·K2+kh)·K3+kw)·DATA_W +: DATA_W]
- `last_in` in 1: qualifies the final voxel of the volume (sampled only with valid_in)
- `voxel_out` out OUT_W: convolution result
- `valid_out` out 1: voxel_out holds a new result
- `done` out 1: one-cycle volume-complete pulse

## Operation
- Voxel accepted on a rising edge with valid_in=1; valid_in=0 cycles change no state (stall).
- Position counters (w,h,d) track the accepted voxel; w wraps at W-1 → h++, h wraps at H-1 → d++, d wraps at D-1 → 0.
- Accepting a voxel with last_in=1 zeroes all counters after that voxel, regardless of count (early last_in truncates the volume).
- Delay buffer: circular, depth L = (K1-1)·H·W + (K2-1)·W + (K3-1) voxels plus the current input. Tap (kd,kh,kw) = voxel accepted ((K1-1-kd)·H·W + (K2-1-kh)·W + (K3-1-kw)) acceptances earlier; tap (K1-1,K2-1,K3-1) is voxel_in.
- Window valid iff accepted position has d≥K1-1, h≥K2-1, w≥K3-1; result corresponds to output position (d-K1+1, h-K2+1, w-K3+1). No padding ("valid" convolution): (D-K1+1)(H-K2+1)(W-K3+1) results per volume.
- Arithmetic: correlation (kernel not flipped); acc = Σ tap·weight, unsigned, ACC_W bits, no overflow. Result = acc >> DATA_W (weights are Q0.DATA_W), saturated to 2^OUT_W−1.
- kernel is read combinationally; must be held stable during a volume.
- Buffer contents are not cleared by reset or by a new volume; stale data is excluded by position gating only.

## Timing
- Reset values: voxel_out=0, valid_out=0, done=0, counters=0.
- Latency: result registered on the accepting edge; valid_out/voxel_out visible the following cycle, valid_out high exactly one cycle per valid window.
- voxel_out holds its last value while valid_out=0.
- done asserts one cycle after the edge accepting last_in=1, coincident with that voxel's valid_out if any.
- Throughput: one voxel per cycle, no back-pressure.
- Reset mid-volume: outputs and counters clear immediately; the next accepted voxel is position (0,0,0).

## Structure
- Shared package: the `OUT_W`/`ACC_W` derivations, the tap-offset function and the saturation helper.
- One sub-module natural: `conv3d_mac`, the combinational 27-tap multiply-accumulate-shift-saturate datapath; top holds counters, delay buffer and output registers.

## Test plan
- Reset: hold rst for 2 cycles with valid_in toggling → voxel_out=0, valid_out=0, done=0.
- Center impulse: kernel only (1,1,1)=128, input voxel[i]=i mod 256 → first valid_out after input index 8322, value = voxel(1,1,1)·128>>8 = (4096+64+1 mod 256)>>1 = 32; 23064 valid_out pulses total.
- Uniform: all inputs 16, all weights 16 → every result 27·256>>8 = 27.
- Saturation: all inputs 255, all weights 255 → every result 4095.
- Stalls: same as center impulse with random valid_in=0 gaps → identical result sequence, results only on cycles after accepts.
- Framing: last_in at index 32767 → done pulse one cycle later; a second volume produces identical results. A reset at index 5000 followed by a full volume → 23064 correct results.

Source files
------------

// File: rtl/conv_3d_pkg.sv
// -----------------------------------------------------------------------------
// conv_3d_pkg
// Shared definitions for the streaming 3-D convolution engine:
//   - default geometry / data-width parameters
//   - derived widths (result width, accumulator width)
//   - tap_offset(): how many acceptances ago a kernel tap's voxel arrived
//   - sat_shift(): Q0.DATA_W rescale followed by unsigned saturation
// -----------------------------------------------------------------------------
package conv_3d_pkg;

    localparam int DEF_K1     = 3;
    localparam int DEF_K2     = 3;
    localparam int DEF_K3     = 3;
    localparam int DEF_D      = 8;
    localparam int DEF_H      = 64;
    localparam int DEF_W      = 64;
    localparam int DEF_DATA_W = 8;

    function automatic int calc_out_w(input int data_w);
        return data_w + 4;
    endfunction

    // Wide enough that summing n_taps full-scale products cannot overflow.
    function automatic int calc_acc_w(input int data_w, input int n_taps);
        return 2 * data_w + $clog2(n_taps);
    endfunction

    // Tap (kd,kh,kw) holds the voxel accepted this many acceptances ago.
    // Tap (0,0,0) is the oldest and its offset equals the delay-buffer depth.
    function automatic int tap_offset(input int kd, input int kh, input int kw,
                                      input int k1, input int k2, input int k3,
                                      input int h,  input int w);
        return (k1 - 1 - kd) * h * w + (k2 - 1 - kh) * w + (k3 - 1 - kw);
    endfunction

    // Drop the fractional weight bits, then clamp to the largest out_w value.
    function automatic logic [63:0] sat_shift(input logic [63:0] acc,
                                              input int shift, input int out_w);
        logic [63:0] v;
        logic [63:0] max_v;
        v     = acc >> shift;
        max_v = (64'd1 << out_w) - 64'd1;
        return (v > max_v) ? max_v : v;
    endfunction

endpackage

// File: rtl/conv_3d_if.sv
// -----------------------------------------------------------------------------
// conv_3d_if
// Stream bundle between a volume source and the convolution engine.
// Handshake: valid-only, no back-pressure. A voxel transfers on every rising
// edge where valid_in=1; last_in is meaningful only alongside valid_in.
// valid_out is a one-cycle strobe per result; done is a one-cycle pulse.
//   voxel_in  : input voxel (unsigned)          valid_in  : voxel_in valid
//   kernel    : flattened weights, stable/volume last_in   : final voxel
//   voxel_out : saturated result                valid_out : new result
//   done      : volume complete
// master = volume source / bench side, slave = engine side.
// -----------------------------------------------------------------------------
interface conv_3d_if #(
    parameter int DATA_W = conv_3d_pkg::DEF_DATA_W,
    parameter int N_TAPS = conv_3d_pkg::DEF_K1 * conv_3d_pkg::DEF_K2 * conv_3d_pkg::DEF_K3,
    parameter int OUT_W  = conv_3d_pkg::calc_out_w(conv_3d_pkg::DEF_DATA_W)
);
    logic [DATA_W-1:0]        voxel_in;
    logic                     valid_in;
    logic [N_TAPS*DATA_W-1:0] kernel;
    logic                     last_in;
    logic [OUT_W-1:0]         voxel_out;
    logic                     valid_out;
    logic                     done;

    modport master (
        output voxel_in, valid_in, kernel, last_in,
        input  voxel_out, valid_out, done
    );

    modport slave (
        input  voxel_in, valid_in, kernel, last_in,
        output voxel_out, valid_out, done
    );
endinterface

// File: rtl/conv_3d_mac.sv
// -----------------------------------------------------------------------------
// conv3d_mac
// Combinational datapath: N_TAPS unsigned multiplies, adder tree, shift by
// DATA_W (weights are Q0.DATA_W) and saturation to OUT_W bits.
//   i_taps   : window voxels, tap i at [i*DATA_W +: DATA_W]
//   i_kernel : weights, same layout as i_taps (correlation, no flip)
//   o_result : saturated result
// -----------------------------------------------------------------------------
module conv3d_mac
    import conv_3d_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int N_TAPS = DEF_K1 * DEF_K2 * DEF_K3,
    parameter int OUT_W  = calc_out_w(DEF_DATA_W)
) (
    input  logic [N_TAPS*DATA_W-1:0] i_taps,
    input  logic [N_TAPS*DATA_W-1:0] i_kernel,
    output logic [OUT_W-1:0]         o_result
);
    localparam int ACC_W = calc_acc_w(DATA_W, N_TAPS);

    logic [2*DATA_W-1:0] w_prod [N_TAPS];
    logic [ACC_W-1:0]    w_acc;

    for (genvar i = 0; i < N_TAPS; i++) begin : g_mul
        assign w_prod[i] = {{DATA_W{1'b0}}, i_taps[i*DATA_W +: DATA_W]}
                         * {{DATA_W{1'b0}}, i_kernel[i*DATA_W +: DATA_W]};
    end

    always_comb begin
        w_acc = '0;
        for (int i = 0; i < N_TAPS; i++) begin
            w_acc = w_acc + ACC_W'(w_prod[i]);
        end
    end

    assign o_result = OUT_W'(sat_shift(64'(w_acc), DATA_W, OUT_W));
endmodule

// File: rtl/conv_3d.sv
// -----------------------------------------------------------------------------
// conv_3d
// Streaming K1xK2xK3 "valid" 3-D convolution over a DxHxW volume delivered in
// raster order (w fastest, then h, then d). A circular delay buffer of the
// last L voxels plus the live input supplies every window tap; position
// counters decide whether the current window is fully inside the volume.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : conv_3d_if slave (voxel_in/valid_in/kernel/last_in in,
//              voxel_out/valid_out/done out)
// -----------------------------------------------------------------------------
module conv_3d
    import conv_3d_pkg::*;
#(
    parameter int K1     = DEF_K1,
    parameter int K2     = DEF_K2,
    parameter int K3     = DEF_K3,
    parameter int D      = DEF_D,
    parameter int H      = DEF_H,
    parameter int W      = DEF_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic     clk,
    input  logic     rst,
    conv_3d_if.slave bus
);
    localparam int N_TAPS = K1 * K2 * K3;
    localparam int OUT_W  = calc_out_w(DATA_W);
    localparam int L      = tap_offset(0, 0, 0, K1, K2, K3, H, W);
    localparam int MEM_D  = (L > 0) ? L : 1;
    localparam int PTR_W  = $clog2(MEM_D + 1);
    localparam int WC_W   = $clog2((W > 1) ? W : 2);
    localparam int HC_W   = $clog2((H > 1) ? H : 2);
    localparam int DC_W   = $clog2((D > 1) ? D : 2);

    logic [DATA_W-1:0]        r_mem [MEM_D];
    logic [PTR_W-1:0]         r_wptr;
    logic [WC_W-1:0]          r_w;
    logic [HC_W-1:0]          r_h;
    logic [DC_W-1:0]          r_d;
    logic [OUT_W-1:0]         r_voxel_out;
    logic                     r_valid_out;
    logic                     r_done;
    logic [N_TAPS*DATA_W-1:0] w_taps;
    logic [OUT_W-1:0]         w_result;
    logic                     w_win_valid;

    // Tap gather. r_wptr is the slot the next voxel lands in, so the voxel
    // accepted OFF acceptances ago sits at r_wptr-OFF (mod MEM_D). The oldest
    // tap reads the slot being overwritten this edge, before the write lands.
    for (genvar kd = 0; kd < K1; kd++) begin : g_d
        for (genvar kh = 0; kh < K2; kh++) begin : g_h
            for (genvar kw = 0; kw < K3; kw++) begin : g_w
                localparam int OFF = tap_offset(kd, kh, kw, K1, K2, K3, H, W);
                localparam int IDX = (kd * K2 + kh) * K3 + kw;
                if (OFF == 0) begin : g_live
                    assign w_taps[IDX*DATA_W +: DATA_W] = bus.voxel_in;
                end else begin : g_hist
                    logic [PTR_W-1:0] w_rd;
                    assign w_rd = (r_wptr >= PTR_W'(OFF)) ? r_wptr - PTR_W'(OFF)
                                                          : r_wptr + PTR_W'(MEM_D - OFF);
                    assign w_taps[IDX*DATA_W +: DATA_W] = r_mem[w_rd];
                end
            end
        end
    end

    conv3d_mac #(
        .DATA_W (DATA_W),
        .N_TAPS (N_TAPS),
        .OUT_W  (OUT_W)
    ) u_mac (
        .i_taps   (w_taps),
        .i_kernel (bus.kernel),
        .o_result (w_result)
    );

    // Every tap belongs to the current volume exactly when the newest voxel
    // is at least K-1 deep on all three axes; older buffer contents are
    // simply never selected.
    assign w_win_valid = (r_d >= DC_W'(K1 - 1)) && (r_h >= HC_W'(K2 - 1))
                      && (r_w >= WC_W'(K3 - 1));

    // Buffer storage carries no reset: stale contents are gated out above.
    always_ff @(posedge clk) begin
        if (bus.valid_in && !rst) begin
            r_mem[r_wptr] <= bus.voxel_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr      <= '0;
            r_w         <= '0;
            r_h         <= '0;
            r_d         <= '0;
            r_voxel_out <= '0;
            r_valid_out <= 1'b0;
            r_done      <= 1'b0;
        end else if (bus.valid_in) begin
            r_wptr      <= (r_wptr == PTR_W'(MEM_D - 1)) ? '0 : r_wptr + 1'b1;
            r_valid_out <= w_win_valid;
            r_done      <= bus.last_in;
            if (w_win_valid) begin
                r_voxel_out <= w_result;
            end
            // last_in restarts the raster even if the volume was short.
            if (bus.last_in) begin
                r_w <= '0;
                r_h <= '0;
                r_d <= '0;
            end else if (r_w == WC_W'(W - 1)) begin
                r_w <= '0;
                if (r_h == HC_W'(H - 1)) begin
                    r_h <= '0;
                    r_d <= (r_d == DC_W'(D - 1)) ? '0 : r_d + 1'b1;
                end else begin
                    r_h <= r_h + 1'b1;
                end
            end else begin
                r_w <= r_w + 1'b1;
            end
        end else begin
            r_valid_out <= 1'b0;
            r_done      <= 1'b0;
        end
    end

    assign bus.voxel_out = r_voxel_out;
    assign bus.valid_out = r_valid_out;
    assign bus.done      = r_done;
endmodule

// File: tb/tb_conv_3d.sv
module tb_conv_3d;
  import conv_3d_pkg::*;

  localparam int K1 = 3, K2 = 3, K3 = 3, D = 8, H = 64, W = 64, DATA_W = 8;
  localparam int NT = K1 * K2 * K3;
  localparam int OUT_W = calc_out_w(DATA_W);
  localparam int NVOX = D * H * W;
  localparam int OUT_MAX = (1 << OUT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_3d_if #(.DATA_W(DATA_W), .N_TAPS(NT), .OUT_W(OUT_W)) bus ();

  conv_3d #(
    .K1(K1), .K2(K2), .K3(K3), .D(D), .H(H), .W(W), .DATA_W(DATA_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- bench state ----------------
  int unsigned vol [NVOX];
  int unsigned wt [NT];
  logic [OUT_W-1:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;
  int n_acc;
  int vol_pulses;
  int done_pulses;
  int first_acc;
  logic [OUT_W-1:0] first_val;
  logic [OUT_W-1:0] hold_exp = '0;
  logic acc_edge = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  // mode 0: ramp i mod 256, 1: all 16, 2: all 255, 3: random
  task automatic fill_vol(input int mode);
    for (int i = 0; i < NVOX; i++) begin
      case (mode)
        0: vol[i] = i % 256;
        1: vol[i] = 16;
        2: vol[i] = 255;
        default: vol[i] = $urandom_range(255);
      endcase
    end
  endtask

  // mode 0: centre tap 128 only, 1: all 16, 2: all 255, 3: random
  task automatic set_kernel(input int mode);
    for (int i = 0; i < NT; i++) begin
      case (mode)
        0: wt[i] = (i == ((1 * K2 + 1) * K3 + 1)) ? 128 : 0;
        1: wt[i] = 16;
        2: wt[i] = 255;
        default: wt[i] = $urandom_range(255);
      endcase
      bus.kernel[i*DATA_W +: DATA_W] = wt[i][DATA_W-1:0];
    end
  endtask

  // Reference: direct valid-mode correlation over the volume array. A result
  // exists for every output position whose bottom-far corner voxel was sent.
  task automatic build_expected(input int n_sent);
    for (int od = 0; od <= D - K1; od++)
      for (int oh = 0; oh <= H - K2; oh++)
        for (int ow = 0; ow <= W - K3; ow++) begin
          int corner;
          longint unsigned acc;
          corner = (od + K1 - 1) * H * W + (oh + K2 - 1) * W + (ow + K3 - 1);
          if (corner < n_sent) begin
            acc = 0;
            for (int kd = 0; kd < K1; kd++)
              for (int kh = 0; kh < K2; kh++)
                for (int kw = 0; kw < K3; kw++)
                  acc += longint'(vol[(od + kd) * H * W + (oh + kh) * W + (ow + kw)]
                                  * wt[(kd * K2 + kh) * K3 + kw]);
            acc = acc >> DATA_W;
            if (acc > OUT_MAX) acc = OUT_MAX;
            exp_q.push_back(OUT_W'(acc));
          end
        end
  endtask

  // Driver: streams vol[0..n-1] with random idle gaps; last_in on final voxel if requested.
  task automatic send_volume(input int n, input int stall_pct, input bit do_last);
    n_acc = 0;
    vol_pulses = 0;
    done_pulses = 0;
    first_acc = -1;
    for (int i = 0; i < n; i++) begin
      while (int'($urandom_range(99)) < stall_pct) begin
        bus.valid_in = 1'b0;
        bus.voxel_in = DATA_W'($urandom);
        @(posedge clk); #1;
      end
      bus.valid_in = 1'b1;
      bus.voxel_in = vol[i][DATA_W-1:0];
      bus.last_in = do_last && (i == n - 1);
      @(posedge clk); #1;
      n_acc++;
      bus.valid_in = 1'b0;
      bus.last_in = 1'b0;
    end
    if (do_last) begin
      @(negedge clk);
      check_eq("done_pulse", 32'(bus.done), 1);
      repeat (3) @(negedge clk);
      check_eq("drain", exp_q.size(), 0);
      check_eq("done_count", done_pulses, 1);
    end
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      bus.valid_in = ~bus.valid_in;
      bus.voxel_in = DATA_W'($urandom);
    end
    @(negedge clk);
    check_eq("rst_voxel_out", 32'(bus.voxel_out), 0);
    check_eq("rst_valid_out", 32'(bus.valid_out), 0);
    check_eq("rst_done", 32'(bus.done), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.valid_in = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(posedge clk) acc_edge <= bus.valid_in;

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      hold_exp = '0;
    end else if (bus.valid_out === 1'b1) begin
      check_eq("out_after_accept", 32'(acc_edge), 1);
      if (first_acc < 0) begin
        first_acc = n_acc;
        first_val = bus.voxel_out;
      end
      vol_pulses++;
      check_eq("result_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        hold_exp = exp_q.pop_front();
        check_eq("result", 32'(bus.voxel_out), 32'(hold_exp));
      end
    end else begin
      check_eq("valid_out_low", 32'(bus.valid_out), 0);
      check_eq("hold", 32'(bus.voxel_out), 32'(hold_exp));
    end
    if (bus.done === 1'b1) done_pulses++;
  end

  // ---------------- watchdog ----------------
  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n_exp;
    rst = 1'b1;
    bus.valid_in = 1'b0;
    bus.voxel_in = '0;
    bus.last_in = 1'b0;
    bus.kernel = '0;
    n_acc = 0;
    vol_pulses = 0;
    done_pulses = 0;
    first_acc = -1;
    first_val = '0;
    reset_pulse();

    // Centre impulse, ramp input, random stalls, full volume.
    fill_vol(0);
    set_kernel(0);
    build_expected(NVOX);
    send_volume(NVOX, 10, 1'b1);
    check_eq("impulse_pulses", vol_pulses, 23064);
    check_eq("impulse_first_acc", first_acc, 8323);
    check_eq("impulse_first_val", 32'(first_val), 32);

    // Uniform 16/16, truncated by an early last_in (3 rows of results).
    fill_vol(1);
    set_kernel(1);
    build_expected(8514);
    n_exp = exp_q.size();
    send_volume(8514, 0, 1'b1);
    check_eq("uniform_pulses", vol_pulses, n_exp);
    check_eq("uniform_first_val", 32'(first_val), 27);
    check_eq("uniform_first_acc", first_acc, 8323);

    // Saturation 255/255, truncated, with stalls.
    fill_vol(2);
    set_kernel(2);
    build_expected(8514);
    n_exp = exp_q.size();
    send_volume(8514, 20, 1'b1);
    check_eq("sat_pulses", vol_pulses, n_exp);
    check_eq("sat_first_val", 32'(first_val), 4095);

    // Random volume aborted by reset at index 5000, then a fresh random volume.
    fill_vol(3);
    set_kernel(3);
    send_volume(5000, 5, 1'b0);
    reset_pulse();
    check_eq("post_rst_pulses", vol_pulses, 0);
    fill_vol(3);
    set_kernel(3);
    build_expected(12000);
    n_exp = exp_q.size();
    send_volume(12000, 15, 1'b1);
    check_eq("rand_pulses", vol_pulses, n_exp);
    check_eq("rand_first_acc", first_acc, 8323);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
